// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Operand/result handshake bundle for the bit-serial adder.
//               The master side produces operands and consumes results;
//               the slave side is the adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_ci;
  logic                  in_vld;
  logic                  in_rd;
  logic [DATA_WIDTH-1:0] out_s;
  logic                  out_co;
  logic                  out_vld;
  logic                  out_rd;
  logic                  busy;

  modport master (
    output in_a, in_b, in_ci, in_vld, out_rd,
    input  in_rd, out_s, out_co, out_vld, busy
  );

  modport slave (
    input  in_a, in_b, in_ci, in_vld, out_rd,
    output in_rd, out_s, out_co, out_vld, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. A single full-adder cell is
//               reused for DATA_WIDTH cycles to produce a DATA_WIDTH-bit sum
//               plus carry-out, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int DATA_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] a_sh_q;
  logic [DATA_WIDTH-1:0] b_sh_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  carry_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  in_rd_q;
  logic                  out_vld_q;
  logic                  busy_q;

  logic                  s_d;
  logic                  co_d;
  logic [DATA_WIDTH-1:0] sum_shift_d;

  // The one shared full-adder cell, fed by the LSBs of the operand shifters.
  always_comb begin
    s_d  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    co_d = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  end

  // New sum bits enter at the MSB so that after DATA_WIDTH shifts bit i sits at i.
  if (DATA_WIDTH == 1) begin : g_sum_w1
    assign sum_shift_d = s_d;
  end else begin : g_sum_wn
    assign sum_shift_d = {s_d, sum_q[DATA_WIDTH-1:1]};
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      in_rd_q   <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_vld && in_rd_q) begin
            a_sh_q  <= bus.in_a;
            b_sh_q  <= bus.in_b;
            carry_q <= bus.in_ci;
            cnt_q   <= '0;
            in_rd_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= co_d;
          sum_q   <= sum_shift_d;
          if (cnt_q == c_CNT_LAST) begin
            out_vld_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Sum and carry registers are untouched here, so they hold under backpressure.
          if (bus.out_rd) begin
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            in_rd_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          out_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          in_rd_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_rd   = in_rd_q;
  assign bus.out_vld = out_vld_q;
  assign bus.busy    = busy_q;
  assign bus.out_s   = sum_q;
  assign bus.out_co  = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl at DATA_WIDTH 4, 1
//               and 8 sharing one clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.DATA_WIDTH(4)) if4 ();
  serial_adder_ctrl_if #(.DATA_WIDTH(1)) if1 ();
  serial_adder_ctrl_if #(.DATA_WIDTH(8)) if8 ();

  serial_adder_ctrl #(.DATA_WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_adder_ctrl #(.DATA_WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_adder_ctrl #(.DATA_WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
  } vec_t;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One complete operation on the 4-bit instance, out_rd held high.
  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [3:0] es, input logic eco);
    int n;
    int lat;
    logic run_ok;
    if4.in_a = a; if4.in_b = b; if4.in_ci = ci; if4.in_vld = 1'b1; if4.out_rd = 1'b1;
    n = 0;
    while (!if4.in_rd && n < 50) begin tick; n++; end
    chk("w4_ready_before_accept", if4.in_rd, 1);
    tick;
    if4.in_vld = 1'b0;
    lat = 1; run_ok = 1'b1;
    while (!if4.out_vld && lat < 50) begin
      if (if4.in_rd !== 1'b0 || if4.busy !== 1'b1) run_ok = 1'b0;
      tick; lat++;
    end
    chk("w4_latency", lat, 5);
    chk("w4_run_flags", run_ok, 1);
    chk("w4_done_flags", {if4.in_rd, if4.busy}, 2'b01);
    chk("w4_sum", {if4.out_co, if4.out_s}, {eco, es});
    tick;
    chk("w4_back_to_idle", {if4.out_vld, if4.in_rd, if4.busy}, 3'b010);
  endtask

  // One complete operation on the 1-bit instance, out_rd held high.
  task automatic run_op1(input logic a, input logic b, input logic ci,
                         input logic es, input logic eco);
    int n;
    int lat;
    if1.in_a = a; if1.in_b = b; if1.in_ci = ci; if1.in_vld = 1'b1; if1.out_rd = 1'b1;
    n = 0;
    while (!if1.in_rd && n < 50) begin tick; n++; end
    tick;
    if1.in_vld = 1'b0;
    lat = 1;
    while (!if1.out_vld && lat < 50) begin tick; lat++; end
    chk("w1_latency", lat, 2);
    chk("w1_sum", {if1.out_co, if1.out_s}, {eco, es});
    tick;
  endtask

  vec_t vec4 [8];
  vec_t vec1 [8];

  initial begin
    int n;
    int seen;
    logic stable;
    int unsigned issued;
    int unsigned done;
    int unsigned cyc;
    logic acc;
    logic [8:0] q[$];
    logic [8:0] exp9;

    // {a, b, ci, sum, carry-out}, hand-computed.
    vec4[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
    vec4[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    vec4[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vec4[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vec4[4] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    vec4[5] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
    vec4[6] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0};
    vec4[7] = '{4'h9, 4'h9, 1'b0, 4'h2, 1'b1};
    // Full-adder truth table.
    vec1[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vec1[1] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    vec1[2] = '{4'h0, 4'h1, 1'b0, 4'h1, 1'b0};
    vec1[3] = '{4'h0, 4'h1, 1'b1, 4'h0, 1'b1};
    vec1[4] = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0};
    vec1[5] = '{4'h1, 4'h0, 1'b1, 4'h0, 1'b1};
    vec1[6] = '{4'h1, 4'h1, 1'b0, 4'h0, 1'b1};
    vec1[7] = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b1};

    if4.in_a = '0; if4.in_b = '0; if4.in_ci = 1'b0; if4.in_vld = 1'b0; if4.out_rd = 1'b0;
    if1.in_a = '0; if1.in_b = '0; if1.in_ci = 1'b0; if1.in_vld = 1'b0; if1.out_rd = 1'b0;
    if8.in_a = '0; if8.in_b = '0; if8.in_ci = 1'b0; if8.in_vld = 1'b0; if8.out_rd = 1'b0;

    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("reset_flags", {if4.in_rd, if4.out_vld, if4.busy}, 3'b100);
    chk("reset_sum", {if4.out_co, if4.out_s}, 5'h00);

    // Reset together with in_vld: nothing is accepted.
    rst = 1'b1; if4.in_vld = 1'b1; if4.in_a = 4'h5;
    tick;
    rst = 1'b0; if4.in_vld = 1'b0;
    tick;
    chk("rst_vs_vld", {if4.in_rd, if4.busy, if4.out_vld}, 3'b100);

    for (int i = 0; i < 8; i++)
      run_op4(vec4[i].a, vec4[i].b, vec4[i].ci, vec4[i].s, vec4[i].co);

    // Backpressure with new operands waiting.
    if4.in_a = 4'h2; if4.in_b = 4'h4; if4.in_ci = 1'b1; if4.in_vld = 1'b1; if4.out_rd = 1'b0;
    tick;
    if4.in_vld = 1'b0;
    n = 0;
    while (!if4.out_vld && n < 50) begin tick; n++; end
    chk("bp_vld_rises", if4.out_vld, 1);
    if4.in_a = 4'h5; if4.in_b = 4'h6; if4.in_ci = 1'b0; if4.in_vld = 1'b1;
    stable = 1'b1;
    repeat (6) begin
      if (if4.out_s !== 4'h7 || if4.out_co !== 1'b0 || if4.in_rd !== 1'b0 || if4.out_vld !== 1'b1)
        stable = 1'b0;
      tick;
    end
    chk("bp_hold_stable", stable, 1);
    chk("bp_held_sum", {if4.out_co, if4.out_s}, 5'h07);
    if4.out_rd = 1'b1;
    tick;
    chk("bp_idle_ready", {if4.in_rd, if4.out_vld}, 2'b10);
    tick;
    if4.in_vld = 1'b0; if4.in_a = 4'hF; if4.in_b = 4'hF; if4.in_ci = 1'b1;
    chk("bp_pending_accepted", {if4.in_rd, if4.busy}, 2'b01);
    n = 0;
    while (!if4.out_vld && n < 50) begin tick; n++; end
    chk("bp_pending_sum", {if4.out_co, if4.out_s}, 5'h0B);
    tick;

    // Reset in the second RUN cycle discards the operation.
    if4.in_a = 4'h9; if4.in_b = 4'h9; if4.in_ci = 1'b0; if4.in_vld = 1'b1;
    chk("midrun_ready", if4.in_rd, 1);
    tick;
    if4.in_vld = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrun_reset_flags", {if4.in_rd, if4.out_vld, if4.busy}, 3'b100);
    chk("midrun_reset_sum", {if4.out_co, if4.out_s}, 5'h00);
    seen = 0;
    repeat (10) begin
      if (if4.out_vld) seen++;
      tick;
    end
    chk("midrun_no_vld", seen, 0);
    run_op4(4'h6, 4'h7, 1'b0, 4'hD, 1'b0);

    for (int i = 0; i < 8; i++)
      run_op1(vec1[i].a[0], vec1[i].b[0], vec1[i].ci, vec1[i].s[0], vec1[i].co);

    // Randomised 8-bit regression with stalls on both sides.
    issued = 0; done = 0; cyc = 0;
    while (done < 1000 && cyc < 60000) begin
      if (!if8.in_vld && issued < 1000 && $urandom_range(0, 3) != 0) begin
        if8.in_a = 8'($urandom); if8.in_b = 8'($urandom); if8.in_ci = 1'($urandom);
        if8.in_vld = 1'b1;
      end
      if8.out_rd = ($urandom_range(0, 2) != 0);
      acc = if8.in_vld && if8.in_rd;
      if (acc) begin
        q.push_back(9'(if8.in_a) + 9'(if8.in_b) + 9'(if8.in_ci));
        issued++;
      end
      if (if8.out_vld && if8.out_rd) begin
        if (q.size() == 0) chk("w8_spurious_result", 1, 0);
        else begin
          exp9 = q.pop_front();
          chk("w8_result", {if8.out_co, if8.out_s}, exp9);
        end
        done++;
      end
      tick;
      cyc++;
      if (acc) if8.in_vld = 1'b0;
    end
    chk("w8_result_count", done, 1000);
    chk("w8_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
